// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan driver.
//   Segment bit order (all codes active-low): {dp, g, f, e, d, c, b, a}
//   SEG_0..SEG_F : full-hex glyph codes with the decimal point off (bit 7 = 1)
//   SEG_BLANK    : every segment and the decimal point off
//   seg7_decode  : nibble -> 7 glyph bits {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code[6:0];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational glyph generator for one digit (active-low outputs).
//   nib_i   : hex value to display
//   dp_i    : 1 lights the decimal point
//   blank_i : 1 forces every segment off (overrides nib_i and dp_i)
//   seg_o   : {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            seg_o = {~dp_i, seg7_decode(nib_i)};
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for DIGITS common-anode seven-segment digits.
//   clk, rst_n   : clock, asynchronous active-low reset
//   data_in      : nibble k is the value of digit k (digit 0 rightmost)
//   dp_in        : per-digit decimal point enable
//   en_in        : per-digit enable (0 = dark)
//   lz_sup       : 1 = blank leading zeros
//   upd          : request to load the inputs at the next frame boundary
//   upd_pending  : a load is waiting for the frame boundary
//   an           : anode selects, active-low, at most one low
//   seg          : {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick   : one-cycle pulse after each frame-boundary cycle
// Only the shadow copy of the inputs is ever displayed, so a load never tears
// a frame in half.
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   en_in,
    input  logic                lz_sup,
    input  logic                upd,
    output logic                upd_pending,
    output logic [DIGITS-1:0]   an,
    output logic [7:0]          seg,
    output logic                frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                upd_pending_q, upd_pending_d;
    logic [4*DIGITS-1:0] sh_data_q;
    logic [DIGITS-1:0]   sh_dp_q, sh_en_q;
    logic                sh_lz_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_tick_q;

    logic                div_wrap, idx_last, boundary, load;
    logic                in_blank, lit;
    logic [3:0]          cur_nib;
    logic [DIGITS-1:0]   lz_run, suppress;
    logic                lz_carry;

    // Slot / frame sequencing
    always_comb begin
        div_wrap      = (div_q == DIV_W'(SCAN_DIV - 1));
        idx_last      = (idx_q == IDX_W'(DIGITS - 1));
        boundary      = div_wrap && idx_last;
        load          = boundary && (upd_pending_q || upd);
        div_d         = div_wrap ? '0 : div_q + DIV_W'(1);
        idx_d         = idx_q;
        if (div_wrap) begin
            idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
        end
        // The boundary cycle always ends any pending request; an upd landing
        // on the boundary itself is consumed there and never shows as pending.
        upd_pending_d = boundary ? 1'b0 : (upd_pending_q || upd);
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (div_q < DIV_W'(BLANK_CYC));
        end
    endgenerate

    // Leading-zero run, scanned from the most significant digit down. A
    // disabled digit is dark anyway, so it counts as part of the run.
    always_comb begin
        lz_carry = 1'b1;
        lz_run   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_carry  = lz_carry && (!sh_en_q[k] ||
                        ((sh_data_q[4*k +: 4] == 4'h0) && !sh_dp_q[k]));
            lz_run[k] = lz_carry;
        end
        // Digit 0 always shows, so an all-zero value still reads "0".
        suppress = sh_lz_q ? (lz_run & ~DIGITS'(1)) : '0;
    end

    always_comb begin
        cur_nib = sh_data_q[{idx_q, 2'b00} +: 4];
        lit     = !in_blank && sh_en_q[idx_q] && !suppress[idx_q];
        an_d    = lit ? ~(DIGITS'(1) << idx_q) : '1;
    end

    seg7_hex_decode u_decode (
        .nib_i   (cur_nib),
        .dp_i    (sh_dp_q[idx_q]),
        .blank_i (!lit),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            idx_q         <= '0;
            upd_pending_q <= 1'b0;
            sh_data_q     <= '0;
            sh_dp_q       <= '0;
            sh_en_q       <= '0;
            sh_lz_q       <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            frame_tick_q  <= 1'b0;
        end else begin
            div_q         <= div_d;
            idx_q         <= idx_d;
            upd_pending_q <= upd_pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_tick_q  <= boundary;
            if (load) begin
                sh_data_q <= data_in;
                sh_dp_q   <= dp_in;
                sh_en_q   <= en_in;
                sh_lz_q   <= lz_sup;
            end
        end
    end

    assign upd_pending = upd_pending_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic        lz_sup = 1'b0;
    logic        upd = 1'b0;
    logic        upd_pending;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int cyc;

    seg7_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .lz_sup      (lz_sup),
        .upd         (upd),
        .upd_pending (upd_pending),
        .an          (an),
        .seg         (seg),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; after posedge n the outputs show state n-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_upd();
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    // Advance to the first cycle showing digit-0 blank of a fresh frame.
    task automatic go_to_frame_start();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((cyc % FRAME) != 1 && n < 80);
        if ((cyc % FRAME) != 1) begin
            total++; bad++;
            $display("FAIL align: cyc=%0d never reached frame start", cyc);
        end
    endtask

    task automatic go_to_phase(input int ph);
        int n;
        n = 0;
        while ((cyc % FRAME) != ph && n < 80) begin
            tick();
            n++;
        end
        if ((cyc % FRAME) != ph) begin
            total++; bad++;
            $display("FAIL align: cyc=%0d never reached phase %0d", cyc, ph);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (an !== 4'hF)        begin bad++; $display("FAIL reset_an: got %h want F", an); end
        total++; if (seg !== 8'hFF)      begin bad++; $display("FAIL reset_seg: got %h want FF", seg); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL reset_pend: got %b want 0", upd_pending); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_frames();
        int ticks;
        logic exp_tick;
        ticks = 0;
        tick();
        for (int i = 0; i < 3 * FRAME; i++) begin
            exp_tick = ((cyc % FRAME) == 0);
            total++;
            if (an !== 4'hF || seg !== 8'hFF || frame_tick !== exp_tick || upd_pending !== 1'b0) begin
                bad++;
                $display("FAIL idle cyc=%0d: an=%h seg=%h tick=%b pend=%b want F FF %b 0",
                         cyc, an, seg, frame_tick, upd_pending, exp_tick);
            end
            if (frame_tick === 1'b1) ticks++;
            tick();
        end
        total++; if (ticks != 3) begin bad++; $display("FAIL idle_tick_count: got %0d want 3", ticks); end
    endtask

    task automatic test_decode_dp();
        logic [7:0] exp [4];
        logic [7:0] es;
        logic [3:0] ea;
        int s, d, v;
        exp = '{8'h99, 8'hB0, 8'h24, 8'hF9};
        data_in = 16'h1234; dp_in = 4'b0100; en_in = 4'hF; lz_sup = 1'b0;
        pulse_upd();
        go_to_frame_start();
        for (int i = 0; i < FRAME; i++) begin
            s = (cyc - 1) % FRAME; d = s / SCAN_DIV; v = s % SCAN_DIV;
            es = (v < BLANK_CYC) ? 8'hFF : exp[d];
            ea = (es == 8'hFF) ? 4'hF : ~(4'b0001 << d);
            total++;
            if (an !== ea || seg !== es) begin
                bad++;
                $display("FAIL decode d%0d v%0d: an=%b seg=%h want an=%b seg=%h", d, v, an, seg, ea, es);
            end
            tick();
        end
    endtask

    task automatic test_lz_sup();
        logic [15:0] tdata [5];
        logic [3:0]  tdp [5];
        logic [3:0]  ten [5];
        logic        tlz [5];
        logic [7:0]  texp [5][4];
        logic [7:0]  es;
        logic [3:0]  ea;
        int s, d, v;
        tdata = '{16'h00A0, 16'h00A0, 16'h0000, 16'h7050, 16'h0000};
        tdp   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        ten   = '{4'hF, 4'hF, 4'hF, 4'b0111, 4'hF};
        tlz   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        texp  = '{'{8'hC0, 8'h88, 8'hFF, 8'hFF},
                  '{8'hC0, 8'h88, 8'hC0, 8'hC0},
                  '{8'hC0, 8'hFF, 8'hFF, 8'hFF},
                  '{8'hC0, 8'h92, 8'hFF, 8'hFF},
                  '{8'hC0, 8'hC0, 8'h40, 8'hFF}};
        for (int t = 0; t < 5; t++) begin
            data_in = tdata[t]; dp_in = tdp[t]; en_in = ten[t]; lz_sup = tlz[t];
            pulse_upd();
            go_to_frame_start();
            for (int i = 0; i < FRAME; i++) begin
                s = (cyc - 1) % FRAME; d = s / SCAN_DIV; v = s % SCAN_DIV;
                es = (v < BLANK_CYC) ? 8'hFF : texp[t][d];
                ea = (es == 8'hFF) ? 4'hF : ~(4'b0001 << d);
                total++;
                if (an !== ea || seg !== es) begin
                    bad++;
                    $display("FAIL lz case%0d d%0d v%0d: an=%b seg=%h want an=%b seg=%h",
                             t, d, v, an, seg, ea, es);
                end
                tick();
            end
        end
    endtask

    task automatic test_upd_timing();
        logic [7:0] exp [4];
        logic [7:0] es;
        logic [3:0] ea;
        int s, d, v, n;
        exp = '{8'h80, 8'hF8, 8'h82, 8'h92};
        go_to_phase(10);
        data_in = 16'h5678; dp_in = 4'b0000; en_in = 4'hF; lz_sup = 1'b0;
        total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL pend_before: got %b want 0", upd_pending); end
        pulse_upd();
        n = 0;
        while ((cyc % FRAME) != 0 && n < 40) begin
            total++;
            if (upd_pending !== 1'b1) begin
                bad++; $display("FAIL pend_hold cyc=%0d: got %b want 1", cyc, upd_pending);
            end
            // A second request while pending must be absorbed.
            upd = ((cyc % FRAME) == 15);
            tick();
            n++;
        end
        upd = 1'b0;
        total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL pend_fall: got %b want 0", upd_pending); end
        total++; if (frame_tick !== 1'b1)  begin bad++; $display("FAIL tick_at_load: got %b want 1", frame_tick); end
        data_in = 16'h9999;
        tick();
        for (int i = 0; i < FRAME; i++) begin
            s = (cyc - 1) % FRAME; d = s / SCAN_DIV; v = s % SCAN_DIV;
            es = (v < BLANK_CYC) ? 8'hFF : exp[d];
            ea = (es == 8'hFF) ? 4'hF : ~(4'b0001 << d);
            total++;
            if (an !== ea || seg !== es) begin
                bad++;
                $display("FAIL upd_hold d%0d v%0d: an=%b seg=%h want an=%b seg=%h", d, v, an, seg, ea, es);
            end
            tick();
        end
        total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL pend_after: got %b want 0", upd_pending); end
    endtask

    task automatic test_enable_boundary_upd();
        logic [7:0] exp [4];
        logic [7:0] es;
        logic [3:0] ea;
        int s, d, v;
        exp = '{8'h8E, 8'h8E, 8'hFF, 8'h8E};
        data_in = 16'hFFFF; dp_in = 4'b0000; en_in = 4'b1011; lz_sup = 1'b0;
        go_to_phase(FRAME - 1);
        pulse_upd();
        total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL bnd_pend0: got %b want 0", upd_pending); end
        total++; if (frame_tick !== 1'b1)  begin bad++; $display("FAIL bnd_tick: got %b want 1", frame_tick); end
        tick();
        total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL bnd_pend1: got %b want 0", upd_pending); end
        for (int i = 0; i < FRAME; i++) begin
            s = (cyc - 1) % FRAME; d = s / SCAN_DIV; v = s % SCAN_DIV;
            es = (v < BLANK_CYC) ? 8'hFF : exp[d];
            ea = (es == 8'hFF) ? 4'hF : ~(4'b0001 << d);
            total++;
            if (an !== ea || seg !== es) begin
                bad++;
                $display("FAIL enable d%0d v%0d: an=%b seg=%h want an=%b seg=%h", d, v, an, seg, ea, es);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        go_to_phase(5);
        total++; if (an !== 4'b1110 || seg !== 8'h8E) begin
            bad++; $display("FAIL pre_reset: an=%b seg=%h want 1110 8E", an, seg);
        end
        pulse_upd();
        total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL pre_reset_pend: got %b want 1", upd_pending); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (an !== 4'hF)          begin bad++; $display("FAIL async_an: got %b want 1111", an); end
        total++; if (seg !== 8'hFF)        begin bad++; $display("FAIL async_seg: got %h want FF", seg); end
        total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL async_pend: got %b want 0", upd_pending); end
        total++; if (frame_tick !== 1'b0)  begin bad++; $display("FAIL async_tick: got %b want 0", frame_tick); end
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2 * FRAME; i++) begin
            total++;
            if (an !== 4'hF || seg !== 8'hFF || upd_pending !== 1'b0) begin
                bad++;
                $display("FAIL post_reset cyc=%0d: an=%b seg=%h pend=%b want 1111 FF 0", cyc, an, seg, upd_pending);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_decode_dp();
        test_lz_sup();
        test_upd_timing();
        test_enable_boundary_upd();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
